ps2_scan_receiver: RTL and testbench
====================================

// Module: ps2_scan_receiver
// PURPOSE
//  Parametrised PS/2 receiver. Synchronises ps2c/ps2d, deframes 11-bit packets with
//  start/odd-parity/stop checks, and folds E0/F0 prefixes into tagged scan codes.
//  Buffers the tagged codes in a show-ahead FIFO for the host.
//  Keeps current/previous make-or-break codes for the hex display path.
// PARAMETERS
//  SYNC_STAGES    2      flip-flops in each ps2c/ps2d synchroniser (>=2)
//  FIFO_DEPTH     8      tagged-code FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES 50000  clk cycles with no ps2c fall before a partial frame is aborted
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-high reset
//  ps2c       in   1   PS/2 clock from keyboard (async)
//  ps2d       in   1   PS/2 data from keyboard (async)
//  rd_en      in   1   pop FIFO head; ignored while empty
//  rd_data    out  10  FIFO head {ext, brk, code[7:0]}; valid while !empty
//  empty      out  1   FIFO empty
//  full       out  1   FIFO full
//  count      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow   out  1   1-cycle pulse: code dropped, FIFO full
//  parity_err out  1   1-cycle pulse: odd-parity check failed
//  frame_err  out  1   1-cycle pulse: bad start/stop bit or timeout
//  curr_code  out  8   most recent non-prefix code
//  prev_code  out  8   code before curr_code
// BEHAVIOUR
//  Reset: clock and reset are as decided above: one clock, clk; reset rst is asynchronous, active-high.
//   On reset: FSM=IDLE, flags/bit counter/timer=0, rd_data=0, empty=1, full=0, count=0.
//   Also: all pulses=0, curr_code=prev_code=0, and any partial frame is discarded.
//  Sync: ps2c and ps2d each pass through SYNC_STAGES flops.
//   fall = synced ps2c 1->0. Data is sampled from synced ps2d on the same cycle as fall.
//  FSM, with transitions on fall only:
//   IDLE:   ps2d=0 -> DATA, bit counter cleared. ps2d=1 -> frame_err pulse, stay in IDLE.
//   DATA:   shift ps2d in LSB-first. After 8 bits -> PARITY.
//   PARITY: capture the parity bit -> STOP.
//   STOP:   evaluate the frame -> IDLE.
//  Frame evaluation on the STOP fall; the result registers take effect at the next edge:
//   stop=0 -> frame_err pulse; code discarded.
//   ^{code,parity}=0 (even) -> parity_err pulse; code discarded.
//   If both fail, frame_err only.
//  Prefix folding on a good frame:
//   0xE0 -> ext flag set; nothing pushed.
//   0xF0 -> brk flag set; nothing pushed.
//   Any other code -> push {ext,brk,code}, then clear ext and brk.
//   On a non-prefix code, prev_code<=curr_code and curr_code<=code. This happens even when the FIFO is full.
//  Timeout: in any state other than IDLE, the timer counts clk cycles since the last fall.
//   At TIMEOUT_CYCLES: FSM->IDLE, bits discarded, frame_err pulse.
//   ext/brk are preserved across a timeout. The timer is cleared on each fall and while in IDLE.
//  Any error clears ext/brk.
//  FIFO is show-ahead; rd_data is always mem[rd_ptr]. Pointers wrap modulo FIFO_DEPTH.
//   Push and pop in the same cycle: both proceed, count unchanged.
//    This holds even when full; no overflow in that case.
//   Push when full without a pop: code dropped, overflow pulse, flags still cleared.
//   Pop when empty: no effect; count stays 0, pointers unchanged.
//  Latency: push is registered 1 clk after the STOP fall.
//   empty falls and count increments at that same edge.
//   Total: SYNC_STAGES+2 clk from the pin-level ps2c stop edge.
// TESTING
//  1. Frame 0x1C (start 0, parity 0, stop 1) -> rd_data=0x01C, count=1, curr_code=0x1C.
//  2. Frames E0,F0,75 -> one entry 0x375; then frame 75 -> entry 0x075, prev=0x75, curr=0x75.
//  3. Frame 0x1C with parity=1 -> parity_err pulse, nothing pushed.
//     Then the same frame with stop=0 -> frame_err pulse, FIFO still empty.
//  4. Push 9 codes with FIFO_DEPTH=8, no reads -> full=1, count=8, exactly one overflow pulse.
//     curr_code = 9th code; pop 8 -> codes 1..8 in order, empty=1.
//  5. Stop ps2c after 5 bits for TIMEOUT_CYCLES -> frame_err pulse; next full frame 0x29 pushed as 0x029.
//  6. Assert rst mid-frame with FIFO count=3 -> all outputs reset in the same cycle; next frame received cleanly.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit packets,
// folds E0/F0 prefixes into tagged scan codes, and queues the tagged codes in a
// show-ahead FIFO. It also keeps the last two non-prefix codes for a display.
module ps2_scan_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rd_en,
  output logic [9:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic [7:0]                    curr_code,
  output logic [7:0]                    prev_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0]    CODE_EXT   = 8'hE0;
  localparam logic [7:0]    CODE_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Reset to 1 (idle bus level) so reset release never
  // looks like a clock fall.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] c_sync_reg;
  logic [SYNC_STAGES-1:0] d_sync_reg;
  logic                   c_prev_reg;
  logic                   c_synced;
  logic                   d_synced;
  logic                   fall;

  assign c_synced = c_sync_reg[SYNC_STAGES-1];
  assign d_synced = d_sync_reg[SYNC_STAGES-1];
  assign fall     = c_prev_reg & ~c_synced;

  // Shift the raw pins through the synchroniser chains and track the last ps2c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync_reg <= '1;
      d_sync_reg <= '1;
      c_prev_reg <= 1'b1;
    end else begin
      c_sync_reg <= {c_sync_reg[SYNC_STAGES-2:0], ps2c};
      d_sync_reg <= {d_sync_reg[SYNC_STAGES-2:0], ps2d};
      c_prev_reg <= c_synced;
    end
  end

  // ---------------------------------------------------------------------------
  // Deframing FSM. Result pulses (good frame, errors) are registered on the
  // STOP fall and consumed by the folding/FIFO logic one edge later.
  // ---------------------------------------------------------------------------
  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] timer_reg;
  logic          good_reg;
  logic [7:0]    code_reg;
  logic          frame_err_reg;
  logic          parity_err_reg;
  logic          flag_clr_reg;   // error that must drop pending E0/F0 prefixes
  logic          odd_ok;

  assign odd_ok = ^{shift_reg, parity_reg};

  // Frame state machine with inactivity timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      timer_reg      <= '0;
      good_reg       <= 1'b0;
      code_reg       <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      flag_clr_reg   <= 1'b0;
    end else begin
      good_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      flag_clr_reg   <= 1'b0;
      if (fall) begin
        timer_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!d_synced) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end else begin
              frame_err_reg <= 1'b1;
              flag_clr_reg  <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {d_synced, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
          PARITY: begin
            parity_reg <= d_synced;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            code_reg  <= shift_reg;
            if (!d_synced) begin
              frame_err_reg <= 1'b1;
              flag_clr_reg  <= 1'b1;
            end else if (!odd_ok) begin
              parity_err_reg <= 1'b1;
              flag_clr_reg   <= 1'b1;
            end else begin
              good_reg <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg == IDLE) begin
        timer_reg <= '0;
      end else if (timer_reg == TIMER_LAST) begin
        // Abandon the partial frame; pending prefixes survive a timeout.
        state_reg     <= IDLE;
        timer_reg     <= '0;
        frame_err_reg <= 1'b1;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix folding and FIFO control.
  // ---------------------------------------------------------------------------
  logic          ext_reg;
  logic          brk_reg;
  logic [7:0]    curr_reg;
  logic [7:0]    prev_reg;
  logic          overflow_reg;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          is_prefix;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          wr_ok;
  logic [9:0]    push_data;

  assign is_prefix = (code_reg == CODE_EXT) || (code_reg == CODE_BRK);
  assign push      = good_reg && !is_prefix;
  assign pop       = rd_en && (count_reg != '0);
  assign fifo_full = (count_reg == COUNT_FULL);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_ok     = push && (!fifo_full || pop);
  assign push_data = {ext_reg, brk_reg, code_reg};

  // Prefix flags, code history and the overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      curr_reg     <= '0;
      prev_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push && fifo_full && !pop;
      if (flag_clr_reg) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (good_reg) begin
        if (code_reg == CODE_EXT) begin
          ext_reg <= 1'b1;
        end else if (code_reg == CODE_BRK) begin
          brk_reg <= 1'b1;
        end else begin
          ext_reg  <= 1'b0;
          brk_reg  <= 1'b0;
          prev_reg <= curr_reg;
          curr_reg <= code_reg;
        end
      end
    end
  end

  // FIFO storage; cleared on reset so the show-ahead head reads 0 when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data    = mem[rd_ptr_reg];
  assign empty      = (count_reg == '0);
  assign full       = fifo_full;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign curr_code  = curr_reg;
  assign prev_code  = prev_reg;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: drives hand-built PS/2 frames and
// compares FIFO contents, flags, error pulses and code history.
module tb_ps2_scan_receiver;

  localparam int SYNC_STAGES    = 2;
  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 4;
  localparam int CW             = $clog2(FIFO_DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          ps2c;
  logic          ps2d;
  logic          rd_en;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          parity_err;
  logic          frame_err;
  logic [7:0]    curr_code;
  logic [7:0]    prev_code;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int par_cnt = 0;
  int frm_cnt = 0;
  int ovf_base;
  int par_base;
  int frm_base;

  ps2_scan_receiver #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .curr_code (curr_code),
    .prev_code (prev_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count single-cycle pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow)   ovf_cnt++;
      if (parity_err) par_cnt++;
      if (frame_err)  frm_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2d = b;
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  // Full frame; par_flip inverts the correct odd parity bit.
  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop_bit);
    logic par;
    par = (~^code) ^ par_flip;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(stop_bit);
    @(posedge clk); #1 ps2d = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic snap();
    ovf_base = ovf_cnt;
    par_base = par_cnt;
    frm_base = frm_cnt;
  endtask

  initial begin
    logic [7:0] code;
    rst   = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h000);
    check("rst_curr", 32'(curr_code), 32'h00);
    check("rst_prev", 32'(prev_code), 32'h00);

    // 1: frame 0x1C, with push latency measured from the pin-level stop fall
    ps2_bit(1'b0);
    code = 8'h1C;
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(1'b0);
    @(posedge clk); #1 ps2d = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 check("lat_count_before", 32'(count), 32'd0);
    @(posedge clk);
    #1 check("lat_count_at", 32'(count), 32'd1);
    ps2c = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t1_rd_data", 32'(rd_data), 32'h01C);
    check("t1_count", 32'(count), 32'd1);
    check("t1_curr", 32'(curr_code), 32'h1C);
    pop_one();
    #1 check("t1_empty_after_pop", 32'(empty), 32'd1);

    // 2: E0 F0 75 folds into one tagged entry, then a plain 75
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    check("t2_prefix_no_push", 32'(count), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1);
    check("t2_tagged", 32'(rd_data), 32'h375);
    check("t2_count1", 32'(count), 32'd1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("t2_count2", 32'(count), 32'd2);
    pop_one();
    #1 check("t2_plain", 32'(rd_data), 32'h075);
    check("t2_prev", 32'(prev_code), 32'h75);
    check("t2_curr", 32'(curr_code), 32'h75);
    pop_one();

    // 3: parity error, then framing error (bad stop)
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t3_parity_pulse", 32'(par_cnt - par_base), 32'd1);
    check("t3_parity_empty", 32'(empty), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3_frame_pulse", 32'(frm_cnt - frm_base), 32'd1);
    check("t3_frame_empty", 32'(empty), 32'd1);
    check("t3_curr_kept", 32'(curr_code), 32'h75);

    // 4: nine pushes into an eight-deep FIFO
    snap();
    for (int k = 0; k < 9; k++) send_frame(8'h10 + 8'(k), 1'b0, 1'b1);
    check("t4_full", 32'(full), 32'd1);
    check("t4_count", 32'(count), 32'd8);
    check("t4_overflow_pulses", 32'(ovf_cnt - ovf_base), 32'd1);
    check("t4_curr", 32'(curr_code), 32'h18);
    check("t4_prev", 32'(prev_code), 32'h17);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_pop%0d", k), 32'(rd_data), 32'h010 + 32'(k));
      pop_one();
      #1;
    end
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_no_parity", 32'(par_cnt - par_base), 32'd0);

    // 5: abandon a frame after five bits, then a clean 0x29
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(posedge clk); #1 ps2d = 1'b1;
    repeat (TIMEOUT_CYCLES + 20) @(posedge clk);
    #1 check("t5_timeout_pulse", 32'(frm_cnt - frm_base), 32'd1);
    check("t5_timeout_empty", 32'(empty), 32'd1);
    send_frame(8'h29, 1'b0, 1'b1);
    check("t5_after", 32'(rd_data), 32'h029);
    check("t5_count", 32'(count), 32'd1);

    // 6: asynchronous reset mid-frame with three entries queued
    send_frame(8'h31, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("t6_count3", 32'(count), 32'd3);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full", 32'(full), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'h000);
    check("t6_curr", 32'(curr_code), 32'h00);
    check("t6_prev", 32'(prev_code), 32'h00);
    ps2d = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap();
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t6_next", 32'(rd_data), 32'h05A);
    check("t6_next_count", 32'(count), 32'd1);
    check("t6_next_curr", 32'(curr_code), 32'h5A);
    check("t6_next_prev", 32'(prev_code), 32'h00);
    check("t6_no_frame_err", 32'(frm_cnt - frm_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
